// File: rtl/cx_pkg.sv
// cx_pkg: shared states, packet layout and default widths for the copy/exchange stage.
package cx_pkg;
  localparam int CX_OP_W = 16;
  localparam int CX_DEST_W = 8;
  localparam int CX_DEPTH = 2;
  localparam logic [CX_DEST_W-1:0] CX_COPY_MASK = 8'h01;
  typedef enum logic [1:0] {S_IDLE, S_SINGLE, S_COPY0, S_COPY1} state_t;
  typedef struct packed {
    logic cpy;
    logic [CX_DEST_W-1:0] dest;
    logic [CX_OP_W-1:0] a;
    logic [CX_OP_W-1:0] b;
  } pkt_t;
endpackage

// File: rtl/cx_fifo.sv
// cx_fifo: synchronous FIFO, async active-low reset, combinational head.
// Ports:
//   clk, rst_n      - clock and reset
//   push, pop       - write / read strobes (caller guarantees not-full / not-empty)
//   din, head       - write data and current head entry
//   count           - occupancy, 0..DEPTH
module cx_fifo #(
  parameter int W = 41,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign head = mem[rp];
  always_ff @(posedge clk) if (push) mem[wp] <= din;
  // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/cx_copy_exchange.sv
// cx_copy_exchange: buffered packet stage applying operand exchange and copy emission.
// Ports:
//   CLK, MR_n                     - clock, async active-low master reset
//   Send_in/Ack_out               - upstream handshake; CPY_in, EXB_in, Dest_in, A_in, B_in payload
//   Send_out/Ack_in               - downstream handshake; Dest_out, A_out, B_out, Cidx_out payload
//   FEB                           - FIFO empty and output stage idle
module cx_copy_exchange
  import cx_pkg::*;
#(
  parameter int OP_W = CX_OP_W,
  parameter int DEST_W = CX_DEST_W,
  parameter int DEPTH = CX_DEPTH,
  parameter logic [DEST_W-1:0] COPY_MASK = DEST_W'(CX_COPY_MASK)
) (
  input  logic              CLK,
  input  logic              MR_n,
  input  logic              Send_in,
  output logic              Ack_out,
  input  logic              CPY_in,
  input  logic              EXB_in,
  input  logic [DEST_W-1:0] Dest_in,
  input  logic [OP_W-1:0]   A_in,
  input  logic [OP_W-1:0]   B_in,
  output logic              Send_out,
  input  logic              Ack_in,
  output logic [DEST_W-1:0] Dest_out,
  output logic [OP_W-1:0]   A_out,
  output logic [OP_W-1:0]   B_out,
  output logic              Cidx_out,
  output logic              FEB
);
  localparam int PW = 1 + DEST_W + 2 * OP_W;
  localparam int CW = $clog2(DEPTH) + 1;
  state_t state;
  logic [PW-1:0] din, head;
  logic [CW-1:0] count;
  logic push, pop, xfer, free, h_cpy;
  logic [DEST_W-1:0] h_dest;
  logic [OP_W-1:0] h_a, h_b;
  assign push = Send_in & Ack_out;
  assign xfer = Send_out & Ack_in;
  // the output register is reusable when idle or when its last beat leaves this edge
  assign free = (state == S_IDLE) | (xfer & ((state == S_SINGLE) | (state == S_COPY1)));
  assign pop = free & (count != '0);
  assign Ack_out = count != CW'(DEPTH);
  assign FEB = (count == '0) & (state == S_IDLE);
  // exchange is resolved before storage so the FIFO holds final operand order
  assign din = {CPY_in, Dest_in, EXB_in ? B_in : A_in, EXB_in ? A_in : B_in};
  assign {h_cpy, h_dest, h_a, h_b} = head;
  cx_fifo #(.W(PW), .DEPTH(DEPTH)) u_fifo (
    .clk(CLK),
    .rst_n(MR_n),
    .push(push),
    .pop(pop),
    .din(din),
    .head(head),
    .count(count)
  );
  always_ff @(posedge CLK or negedge MR_n)
    if (!MR_n) begin
      state <= S_IDLE;
      Send_out <= 1'b0;
      Cidx_out <= 1'b0;
      Dest_out <= '0;
      A_out <= '0;
      B_out <= '0;
    end else if (pop) begin
      state <= h_cpy ? S_COPY0 : S_SINGLE;
      Send_out <= 1'b1;
      Cidx_out <= 1'b0;
      Dest_out <= h_dest;
      A_out <= h_a;
      B_out <= h_b;
    end else if (free) begin
      state <= S_IDLE;
      Send_out <= 1'b0;
      Cidx_out <= 1'b0;
    end else if (xfer && state == S_COPY0) begin
      state <= S_COPY1;
      Cidx_out <= 1'b1;
      Dest_out <= Dest_out ^ COPY_MASK;
    end
endmodule

// File: tb/tb_cx_copy_exchange.sv
// tb_cx_copy_exchange: directed scenario bench for cx_copy_exchange.
module tb_cx_copy_exchange;
  logic CLK = 1'b0;
  logic MR_n, Send_in, Ack_out, CPY_in, EXB_in, Send_out, Ack_in, Cidx_out, FEB;
  logic [7:0] Dest_in, Dest_out;
  logic [15:0] A_in, B_in, A_out, B_out;
  int tests = 0;
  int fails = 0;
  always #5 CLK = ~CLK;
  cx_copy_exchange dut (
    .CLK(CLK), .MR_n(MR_n), .Send_in(Send_in), .Ack_out(Ack_out), .CPY_in(CPY_in),
    .EXB_in(EXB_in), .Dest_in(Dest_in), .A_in(A_in), .B_in(B_in), .Send_out(Send_out),
    .Ack_in(Ack_in), .Dest_out(Dest_out), .A_out(A_out), .B_out(B_out),
    .Cidx_out(Cidx_out), .FEB(FEB)
  );
  task automatic drive(input logic cpy, input logic exb, input logic [7:0] d,
                       input logic [15:0] a, input logic [15:0] b);
    Send_in = 1'b1; CPY_in = cpy; EXB_in = exb; Dest_in = d; A_in = a; B_in = b;
  endtask
  task automatic stop_in();
    Send_in = 1'b0; CPY_in = 1'b0; EXB_in = 1'b0; Dest_in = 8'hEE; A_in = 16'hDEAD; B_in = 16'hBEEF;
  endtask
  task automatic test_reset();
    MR_n = 1'b0; Ack_in = 1'b1; stop_in();
    #1;
    tests++;
    if ({Send_out, Ack_out, FEB, Cidx_out} !== 4'b0110) begin
      fails++; $display("FAIL reset_ctrl got %b want 0110", {Send_out, Ack_out, FEB, Cidx_out});
    end
    tests++;
    if ({Dest_out, A_out, B_out} !== 40'h0) begin
      fails++; $display("FAIL reset_data got %h want 0", {Dest_out, A_out, B_out});
    end
    @(negedge CLK); MR_n = 1'b1;
    @(negedge CLK);
  endtask
  task automatic test_single();
    drive(1'b0, 1'b0, 8'h10, 16'h1111, 16'h2222);
    @(negedge CLK); stop_in();
    tests++;
    if ({Send_out, FEB} !== 2'b00) begin
      fails++; $display("FAIL single_latency got %b want 00", {Send_out, FEB});
    end
    @(negedge CLK);
    tests++;
    if ({Send_out, Cidx_out, Dest_out, A_out, B_out} !== {2'b10, 8'h10, 16'h1111, 16'h2222}) begin
      fails++; $display("FAIL single_beat got %b %b %h %h %h", Send_out, Cidx_out, Dest_out, A_out, B_out);
    end
    @(negedge CLK);
    tests++;
    if ({Send_out, FEB} !== 2'b01) begin
      fails++; $display("FAIL single_done got %b want 01", {Send_out, FEB});
    end
  endtask
  task automatic test_exchange();
    drive(1'b0, 1'b1, 8'h11, 16'hAAAA, 16'h5555);
    @(negedge CLK); stop_in();
    @(negedge CLK);
    tests++;
    if ({Send_out, Dest_out, A_out, B_out} !== {1'b1, 8'h11, 16'h5555, 16'hAAAA}) begin
      fails++; $display("FAIL exchange got %b %h %h %h want 1 11 5555 aaaa", Send_out, Dest_out, A_out, B_out);
    end
    @(negedge CLK);
  endtask
  task automatic test_copy();
    drive(1'b1, 1'b0, 8'h20, 16'h1234, 16'h5678);
    @(negedge CLK); stop_in();
    @(negedge CLK);
    tests++;
    if ({Send_out, Cidx_out, Dest_out, A_out, B_out} !== {2'b10, 8'h20, 16'h1234, 16'h5678}) begin
      fails++; $display("FAIL copy0 got %b %b %h %h %h", Send_out, Cidx_out, Dest_out, A_out, B_out);
    end
    @(negedge CLK);
    tests++;
    if ({Send_out, Cidx_out, Dest_out, A_out, B_out} !== {2'b11, 8'h21, 16'h1234, 16'h5678}) begin
      fails++; $display("FAIL copy1 got %b %b %h %h %h", Send_out, Cidx_out, Dest_out, A_out, B_out);
    end
    @(negedge CLK);
    tests++;
    if ({Send_out, FEB} !== 2'b01) begin
      fails++; $display("FAIL copy_done got %b want 01", {Send_out, FEB});
    end
  endtask
  task automatic test_backpressure();
    logic [7:0] got [8];
    int n = 0;
    Ack_in = 1'b0;
    drive(1'b0, 1'b0, 8'h31, 16'h0031, 16'h1031);
    @(negedge CLK); drive(1'b0, 1'b0, 8'h32, 16'h0032, 16'h1032);
    @(negedge CLK);
    tests++;
    if (Ack_out !== 1'b1) begin
      fails++; $display("FAIL bp_ack_before_full got %b want 1", Ack_out);
    end
    drive(1'b0, 1'b0, 8'h33, 16'h0033, 16'h1033);
    @(negedge CLK); stop_in();
    tests++;
    if ({Ack_out, Send_out, FEB, Dest_out} !== {3'b010, 8'h31}) begin
      fails++; $display("FAIL bp_full got ack=%b send=%b feb=%b dest=%h want 0 1 0 31", Ack_out, Send_out, FEB, Dest_out);
    end
    @(negedge CLK);
    tests++;
    if ({Send_out, Dest_out, A_out, B_out} !== {1'b1, 8'h31, 16'h0031, 16'h1031}) begin
      fails++; $display("FAIL bp_hold got %b %h %h %h", Send_out, Dest_out, A_out, B_out);
    end
    Ack_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (Send_out) begin
        if (n < 8) got[n] = Dest_out;
        n++;
      end
      @(negedge CLK);
    end
    tests++;
    if (n !== 3) begin
      fails++; $display("FAIL bp_beats got %0d want 3", n);
    end else begin
      tests++;
      if ({got[0], got[1], got[2]} !== 24'h313233) begin
        fails++; $display("FAIL bp_order got %h%h%h want 313233", got[0], got[1], got[2]);
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [7:0] got [8];
    int n = 0;
    int first = -1;
    int last = -1;
    int ack_low = 0;
    for (int i = 0; i < 13; i++) begin
      if (!Ack_out) ack_low++;
      if (Send_out) begin
        if (n < 8) got[n] = Dest_out;
        if (first < 0) first = i;
        last = i;
        n++;
      end
      if (i < 8) drive(1'b0, 1'b0, 8'h40 + 8'(i), 16'(i), 16'(i + 100));
      else stop_in();
      @(negedge CLK);
    end
    tests++;
    if (ack_low !== 0) begin
      fails++; $display("FAIL stream_ack got %0d low cycles want 0", ack_low);
    end
    tests++;
    if (n !== 8 || last - first !== 7) begin
      fails++; $display("FAIL stream_beats got %0d beats span %0d want 8 span 7", n, last - first);
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests++;
        if (got[i] !== 8'h40 + 8'(i)) begin
          fails++; $display("FAIL stream_order[%0d] got %h want %h", i, got[i], 8'h40 + 8'(i));
        end
      end
    end
  endtask
  task automatic test_reset_mid();
    int beats = 0;
    Ack_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 8'h50 + 8'(i), 16'h7777, 16'h8888);
      @(negedge CLK);
    end
    stop_in();
    tests++;
    if ({Ack_out, Send_out} !== 2'b01) begin
      fails++; $display("FAIL mid_pre got ack=%b send=%b want 0 1", Ack_out, Send_out);
    end
    #2 MR_n = 1'b0;
    #1;
    tests++;
    if ({Send_out, FEB, Ack_out, Cidx_out, Dest_out} !== {4'b0110, 8'h00}) begin
      fails++; $display("FAIL mid_reset got send=%b feb=%b ack=%b cidx=%b dest=%h", Send_out, FEB, Ack_out, Cidx_out, Dest_out);
    end
    Ack_in = 1'b1;
    @(negedge CLK); MR_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (Send_out || !FEB) beats++;
    end
    tests++;
    if (beats !== 0) begin
      fails++; $display("FAIL mid_after got %0d busy cycles want 0", beats);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_exchange();
    test_copy();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
